// File: rtl/mc_cycle_cpu.sv
// Multi-cycle MIPS-I subset core: one shared req/ready memory port for fetch and data,
// a two-process FSM controller and an internal register file.
module mc_cycle_cpu #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned REG_NUM  = 32
) (
  input  logic              clock,
  input  logic              reset,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic              halted,
  output logic [31:0]       pc_out
);

  localparam int unsigned RIDX_W = $clog2(REG_NUM);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_SYSC  = 6'h0C;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_SLT   = 6'h2A;

  localparam logic [31:0] SYSCALL_IR = 32'h0000_000C;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  state_t              state_q, state_d;
  logic [31:0]         pc_q, pc_d;
  logic [31:0]         ir_q, ir_d;
  logic [31:0]         a_q, a_d;
  logic [31:0]         b_q, b_d;
  logic [31:0]         imm_q, imm_d;
  logic [31:0]         alu_q, alu_d;
  logic [31:0]         mdr_q, mdr_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [31:0]         mem_wdata_q, mem_wdata_d;
  logic                halted_q, halted_d;
  logic [31:0]         rf_q [REG_NUM];

  logic [5:0]          opcode_c, funct_c;
  logic [RIDX_W-1:0]   rs_idx_c, rt_idx_c, rd_idx_c;
  logic [31:0]         rs_val_c, rt_val_c;
  logic                legal_c;
  logic [31:0]         alu_r_c;
  logic [31:0]         data_addr_c;
  logic                fetch_go_c, halt_go_c;
  logic                rf_we_c;
  logic [RIDX_W-1:0]   rf_waddr_c;
  logic [31:0]         rf_wdata_c;

  assign opcode_c    = ir_q[31:26];
  assign funct_c     = ir_q[5:0];
  assign rs_idx_c    = RIDX_W'(ir_q[25:21]);
  assign rt_idx_c    = RIDX_W'(ir_q[20:16]);
  assign rd_idx_c    = RIDX_W'(ir_q[15:11]);
  assign rs_val_c    = (rs_idx_c == '0) ? 32'h0 : rf_q[rs_idx_c];
  assign rt_val_c    = (rt_idx_c == '0) ? 32'h0 : rf_q[rt_idx_c];
  assign data_addr_c = a_q + imm_q;

  // Legal instruction check, evaluated on the freshly fetched IR in DECODE
  always_comb begin
    legal_c = 1'b0;
    case (opcode_c)
      OP_RTYPE: begin
        case (funct_c)
          FN_ADDU, FN_SUBU, FN_AND, FN_OR, FN_SLT, FN_SLL: legal_c = 1'b1;
          FN_SYSC: legal_c = (ir_q == SYSCALL_IR);
          default: legal_c = 1'b0;
        endcase
      end
      OP_J, OP_BEQ, OP_ADDIU, OP_ORI, OP_LUI, OP_LW, OP_SW: legal_c = 1'b1;
      default: legal_c = 1'b0;
    endcase
  end

  // R-type ALU
  always_comb begin
    alu_r_c = 32'h0;
    case (funct_c)
      FN_ADDU: alu_r_c = a_q + b_q;
      FN_SUBU: alu_r_c = a_q - b_q;
      FN_AND:  alu_r_c = a_q & b_q;
      FN_OR:   alu_r_c = a_q | b_q;
      FN_SLT:  alu_r_c = {31'h0, ($signed(a_q) < $signed(b_q))};
      FN_SLL:  alu_r_c = b_q << ir_q[10:6];
      default: alu_r_c = 32'h0;
    endcase
  end

  // Controller: next state, datapath registers and memory port
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    a_d         = a_q;
    b_d         = b_q;
    imm_d       = imm_q;
    alu_d       = alu_q;
    mdr_d       = mdr_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    halted_d    = halted_q;
    fetch_go_c  = 1'b0;
    halt_go_c   = 1'b0;
    rf_we_c     = 1'b0;
    rf_waddr_c  = '0;
    rf_wdata_c  = 32'h0;

    case (state_q)
      S_FETCH: begin
        // Only reachable with mem_req low straight out of reset
        if (!mem_req_q) begin
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = ADDR_W'(pc_q);
        end else if (mem_ready) begin
          ir_d      = mem_rdata;
          pc_d      = pc_q + 32'd4;
          mem_req_d = 1'b0;
          state_d   = S_DECODE;
        end
      end
      S_DECODE: begin
        a_d   = rs_val_c;
        b_d   = rt_val_c;
        imm_d = (opcode_c == OP_ORI) ? {16'h0, ir_q[15:0]} : {{16{ir_q[15]}}, ir_q[15:0]};
        if (legal_c) state_d = S_EXEC;
        else         halt_go_c = 1'b1;
      end
      S_EXEC: begin
        case (opcode_c)
          OP_RTYPE: begin
            if (ir_q == SYSCALL_IR) begin
              halt_go_c = 1'b1;
            end else begin
              alu_d   = alu_r_c;
              state_d = S_WB;
            end
          end
          OP_ADDIU: begin alu_d = a_q + imm_q;            state_d = S_WB; end
          OP_ORI:   begin alu_d = a_q | imm_q;            state_d = S_WB; end
          OP_LUI:   begin alu_d = {ir_q[15:0], 16'h0};    state_d = S_WB; end
          OP_LW, OP_SW: begin
            if (data_addr_c[1:0] != 2'b00) begin
              halt_go_c = 1'b1;
            end else begin
              mem_req_d   = 1'b1;
              mem_we_d    = (opcode_c == OP_SW);
              mem_addr_d  = ADDR_W'(data_addr_c);
              mem_wdata_d = (opcode_c == OP_SW) ? b_q : mem_wdata_q;
              state_d     = S_MEM;
            end
          end
          OP_BEQ: begin
            if (a_q == b_q) pc_d = pc_q + {imm_q[29:0], 2'b00};
            fetch_go_c = 1'b1;
          end
          OP_J: begin
            pc_d       = {pc_q[31:28], ir_q[25:0], 2'b00};
            fetch_go_c = 1'b1;
          end
          default: halt_go_c = 1'b1;
        endcase
      end
      S_MEM: begin
        if (mem_req_q && mem_ready) begin
          if (mem_we_q) begin
            fetch_go_c = 1'b1;
          end else begin
            mdr_d     = mem_rdata;
            mem_req_d = 1'b0;
            state_d   = S_WB;
          end
        end
      end
      S_WB: begin
        rf_waddr_c = (opcode_c == OP_RTYPE) ? rd_idx_c : rt_idx_c;
        rf_wdata_c = (opcode_c == OP_LW) ? mdr_q : alu_q;
        rf_we_c    = (rf_waddr_c != '0);
        fetch_go_c = 1'b1;
      end
      S_HALT: begin
        mem_req_d = 1'b0;
        mem_we_d  = 1'b0;
        halted_d  = 1'b1;
      end
      default: halt_go_c = 1'b1;
    endcase

    // Next fetch is issued on the transition so FETCH can complete in one cycle
    if (fetch_go_c) begin
      state_d    = S_FETCH;
      mem_req_d  = 1'b1;
      mem_we_d   = 1'b0;
      mem_addr_d = ADDR_W'(pc_d);
    end
    if (halt_go_c) begin
      state_d   = S_HALT;
      mem_req_d = 1'b0;
      mem_we_d  = 1'b0;
      halted_d  = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_FETCH;
      pc_q        <= RESET_PC;
      ir_q        <= 32'h0;
      a_q         <= 32'h0;
      b_q         <= 32'h0;
      imm_q       <= 32'h0;
      alu_q       <= 32'h0;
      mdr_q       <= 32'h0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 32'h0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      a_q         <= a_d;
      b_q         <= b_d;
      imm_q       <= imm_d;
      alu_q       <= alu_d;
      mdr_q       <= mdr_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      halted_q    <= halted_d;
    end
  end

  // Register file, written only from WB
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < REG_NUM; i++) rf_q[i] <= 32'h0;
    end else if (rf_we_c) begin
      rf_q[rf_waddr_c] <= rf_wdata_c;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign halted    = halted_q;
  assign pc_out    = pc_q;

endmodule

// File: doc/mc_cycle_cpu.md
Name: mc_cycle_cpu

Overview:
- Multi-cycle successor to the single-cycle core: one shared memory port for instructions and data, an FSM controller, and an internal 32x32 register file.
- Runs a MIPS-I subset. Each instruction takes 3-5 states plus memory wait states.
- Sits as the CPU top below the SoC wrapper. External memory connects over a req/ready handshake.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- ADDR_W, 32, width of mem_addr. The PC is 32 bits internally; the low ADDR_W bits drive the port.
- REG_NUM, 32, number of GPRs. The index width is $clog2(REG_NUM); register 0 always reads as zero.

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high
- mem_req  output  1  memory access request
- mem_we  output  1  1 = store, 0 = load/fetch
- mem_addr  output  ADDR_W  byte address, word aligned
- mem_wdata  output  32  store data
- mem_rdata  input  32  fetch/load data, valid when mem_ready=1
- mem_ready  input  1  access completes on a cycle where mem_req & mem_ready
- halted  output  1  core stopped (syscall, illegal op, misalignment)
- pc_out  output  32  current PC (debug)

Behaviour:
- Reset (asynchronous):
  - pc=RESET_PC, state=FETCH.
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, halted=0.
  - All GPRs = 0.
  - Reset mid-access drops mem_req immediately, with no partial register or PC write.
- Handshake:
  - Outputs are registered.
  - mem_req/addr/we/wdata stay stable while mem_req=1 and until the cycle with mem_ready=1 is sampled.
  - mem_req deasserts the following cycle unless the next state immediately issues a new access.
  - mem_ready while mem_req=0 is ignored.
- States: FETCH, DECODE, EXEC, MEM, WB, HALT.
  - FETCH: req at pc. On ready: IR<=mem_rdata, pc<=pc+4, go to DECODE.
  - DECODE: read rs/rt into A/B; sign- or zero-extend imm16. Illegal opcode/funct goes to HALT.
  - EXEC:
    - R-type/I-type ALU result goes to ALUOut, then WB.
    - lw/sw: addr = A + sext(imm), then MEM.
    - beq: if A==B, pc <= pc + (sext(imm)<<2); then FETCH.
    - j: pc <= {pc[31:28], imm26, 2'b00}; then FETCH.
    - syscall (IR=32'h0000_000C): go to HALT.
  - MEM: lw/sw request issued. lw on ready: MDR<=mem_rdata, then WB. sw on ready: FETCH.
  - WB: write rd (R-type) or rt (I-type/lw); then FETCH.
  - HALT: terminal. halted=1, mem_req=0. Only reset exits.
- Misaligned data address (addr[1:0]!=0) in EXEC goes to HALT with no memory access.
- Supported ops:
  - R-type: addu, subu, and, or, slt (signed), sll (shamt = IR[10:6]).
  - I-type: addiu (sext), ori (zext), lui ({imm,16'b0}).
  - Memory and control: lw, sw, beq, j, syscall.
- Arithmetic is 32-bit wraparound with no overflow traps.
- GPR rules:
  - Writes to $0 are discarded.
  - The register file is written only in WB.
  - Register reads in DECODE see all earlier writes, because WB completes before the next FETCH.
- Zero-wait-memory latency: R/I-type ALU 4 cycles, lw 5, sw 4, beq 3, j 3. Each wait cycle adds 1.

Test Plan:
- Reset: assert reset mid-FETCH with mem_req=1 → mem_req falls in the same cycle. After release, first mem_addr=32'h3000 and pc_out=32'h3000.
- ALU: ori $1,$0,0x1234; lui $2,0x8000; addu $3,$1,$2; slt $4,$2,$1 with zero-wait memory → $3=32'h8000_1234, $4=1, $0 stays 0, each instruction 4 cycles.
- Memory: sw $3,8($0) then lw $5,8($0), with memory inserting 3 wait cycles per access → mem_we=1 with addr 8 and wdata 32'h8000_1234 held stable during the waits; $5=32'h8000_1234.
- Branch/jump:
  - beq $0,$0,-1 at 0x3010 → next fetch 0x3010.
  - beq with unequal operands → fetch 0x3014.
  - j 0x0C01 at 0x3020 → fetch 0x3004.
- Halt: syscall → halted=1 and no further mem_req. lw from address 2 → halted=1 with no MEM access. Opcode 6'h3F → halted=1.
- Illegal write: addiu $0,$0,5 followed by addu $6,$0,$0 → $6=0.
